iterative_mul_unit: RTL and testbench

Multi-cycle integer multiplier in the EX stage of the pipelined RV32 core. It executes the R-type `mul` operation that the ID-stage decoder marks with ALU control code 4'b1010. The unit computes the low 32 bits of rs1×rs2 with an iterative shift-add datapath. While the product is in progress it raises a stall request that freezes IF/ID/EX, then presents the result for one cycle so the pipeline can advance it to MEM/WB.

---
 rtl/iterative_mul_unit_pkg.sv | 21 ++
 rtl/iterative_mul_unit_mul_step.sv | 38 +++
 rtl/iterative_mul_unit.sv | 103 ++++++++++
 tb/tb_iterative_mul_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_mul_unit_pkg.sv
// Shared constants for the iterative multiplier: ALU code, FSM encodings, iteration count.
// MUL_RADIX4_EN selects 2-bit-per-step iteration (16 steps) instead of 1-bit (32 steps).
package iterative_mul_unit_pkg;

   localparam logic [3:0] ALU_MUL = 4'b1010;

   localparam logic [1:0] MUL_IDLE = 2'd0;
   localparam logic [1:0] MUL_BUSY = 2'd1;
   localparam logic [1:0] MUL_DONE = 2'd2;

   localparam int unsigned CNT_W = 5;

`ifdef MUL_RADIX4_EN
   localparam int unsigned MUL_ITERS = 16;
`else
   localparam int unsigned MUL_ITERS = 32;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

endpackage

// File: rtl/iterative_mul_unit_mul_step.sv
// One combinational shift-add iteration of the multiplier datapath.
// MUL_RADIX4_EN consumes two multiplier bits per step, otherwise one.
module iterative_mul_unit_mul_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] mcand,
   input  logic [XLEN-1:0] mplr,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] mcand_nxt,
   output logic [XLEN-1:0] mplr_nxt
);

`ifdef MUL_RADIX4_EN
   logic [XLEN-1:0] mcand_x2;

   assign mcand_x2 = mcand << 1;

   // 3x partial product is built from mcand + 2*mcand; all sums wrap at XLEN
   always_comb begin
      acc_nxt = acc;
      case (mplr[1:0])
         2'd1:    acc_nxt = acc + mcand;
         2'd2:    acc_nxt = acc + mcand_x2;
         2'd3:    acc_nxt = acc + mcand + mcand_x2;
         default: acc_nxt = acc;
      endcase
   end

   assign mcand_nxt = mcand << 2;
   assign mplr_nxt  = mplr >> 2;
`else
   assign acc_nxt   = mplr[0] ? acc + mcand : acc;
   assign mcand_nxt = mcand << 1;
   assign mplr_nxt  = mplr >> 1;
`endif

endmodule

// File: rtl/iterative_mul_unit.sv
// EX-stage iterative multiplier for RV32 mul: low XLEN bits of rs1*rs2, stalls the pipe while busy.
// MUL_RADIX4_EN halves the iteration count; results are identical in both builds.
module iterative_mul_unit
   import iterative_mul_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mul_start_EX,
   input  logic            flush_EX,
   input  logic [XLEN-1:0] rs1_val_EX,
   input  logic [XLEN-1:0] rs2_val_EX,
   output logic            mul_stall_EX,
   output logic            mul_busy_EX,
   output logic            mul_done_EX,
   output logic [XLEN-1:0] mul_result_EX
);

   logic [1:0]       state, state_nxt;
   logic [XLEN-1:0]  mcand, mcand_nxt;
   logic [XLEN-1:0]  mplr, mplr_nxt;
   logic [XLEN-1:0]  acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [XLEN-1:0]  result, result_nxt;

   logic [XLEN-1:0]  step_acc, step_mcand, step_mplr;

   iterative_mul_unit_mul_step #(.XLEN(XLEN)) u_step (
      .acc       (acc),
      .mcand     (mcand),
      .mplr      (mplr),
      .acc_nxt   (step_acc),
      .mcand_nxt (step_mcand),
      .mplr_nxt  (step_mplr)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MUL_IDLE;
         mcand  <= '0;
         mplr   <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         mcand  <= mcand_nxt;
         mplr   <= mplr_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
      end
   end

   // Next-state, datapath update and the combinational stall request
   always_comb begin
      state_nxt    = state;
      mcand_nxt    = mcand;
      mplr_nxt     = mplr;
      acc_nxt      = acc;
      cnt_nxt      = cnt;
      result_nxt   = result;
      mul_stall_EX = 1'b0;

      case (state)
         MUL_IDLE: begin
            if (mul_start_EX && !flush_EX) begin
               mul_stall_EX = 1'b1;
               mcand_nxt    = rs1_val_EX;
               mplr_nxt     = rs2_val_EX;
               acc_nxt      = '0;
               cnt_nxt      = '0;
               state_nxt    = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            mul_stall_EX = 1'b1;
            if (flush_EX) begin
               state_nxt = MUL_IDLE;
            end else begin
               acc_nxt   = step_acc;
               mcand_nxt = step_mcand;
               mplr_nxt  = step_mplr;
               cnt_nxt   = cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  result_nxt = step_acc;
                  state_nxt  = MUL_DONE;
               end
            end
         end
         // the instruction completing here leaves EX, so a held start is not a new request
         MUL_DONE: state_nxt = MUL_IDLE;
         default:  state_nxt = MUL_IDLE;
      endcase
   end

   assign mul_busy_EX   = (state == MUL_BUSY);
   assign mul_done_EX   = (state == MUL_DONE);
   assign mul_result_EX = result;

endmodule

// File: tb/tb_iterative_mul_unit.sv
// Self-checking bench for iterative_mul_unit: transaction-level reference model plus directed literals.
// Honours MUL_RADIX4_EN for the expected latency.
module tb_iterative_mul_unit;

`ifdef MUL_RADIX4_EN
   localparam int ITERS = 16;
`else
   localparam int ITERS = 32;
`endif
   localparam int DONE_CYC = ITERS + 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mul_start_EX;
   logic        flush_EX;
   logic [31:0] rs1_val_EX;
   logic [31:0] rs2_val_EX;
   logic        mul_stall_EX;
   logic        mul_busy_EX;
   logic        mul_done_EX;
   logic [31:0] mul_result_EX;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   bit chk_en = 1'b0;

   iterative_mul_unit #(.XLEN(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mul_start_EX  (mul_start_EX),
      .flush_EX      (flush_EX),
      .rs1_val_EX    (rs1_val_EX),
      .rs2_val_EX    (rs2_val_EX),
      .mul_stall_EX  (mul_stall_EX),
      .mul_busy_EX   (mul_busy_EX),
      .mul_done_EX   (mul_done_EX),
      .mul_result_EX (mul_result_EX)
   );

   always #5 clk = ~clk;

   // Reference: 0 = waiting, 1 = product in flight, 2 = product presented
   int          m_mode = 0;
   int          m_left = 0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_result = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode   = 0;
         m_left   = 0;
         m_result = '0;
      end else begin
         case (m_mode)
            0: if (mul_start_EX && !flush_EX) begin
                  m_prod = rs1_val_EX * rs2_val_EX;
                  m_left = ITERS;
                  m_mode = 1;
               end
            1: if (flush_EX) m_mode = 0;
               else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_mode   = 2;
                     m_result = m_prod;
                  end
               end
            default: m_mode = 0;
         endcase
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the reference
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", 32'(mul_stall_EX),
               32'((m_mode == 0 && mul_start_EX && !flush_EX) || m_mode == 1));
         check("busy", 32'(mul_busy_EX), 32'(m_mode == 1));
         check("done", 32'(mul_done_EX), 32'(m_mode == 2));
         check("result", mul_result_EX, m_result);
         if (mul_done_EX) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one mul in the current cycle (cycle 1), hold start until done; optional late rs1 change
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int chg_cyc);
      int got = 0;
      mul_start_EX = 1'b1;
      flush_EX     = 1'b0;
      rs1_val_EX   = a;
      rs2_val_EX   = b;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (cyc == chg_cyc) rs1_val_EX = '0;
         @(negedge clk);
         if (cyc == 1) check("stall_c1", 32'(mul_stall_EX), 32'd1);
         if (mul_done_EX) begin
            got = cyc;
            break;
         end
         tick();
      end
      check("done_cycle", 32'(got), 32'(DONE_CYC));
      check("lit_result", mul_result_EX, exp);
      check("stall_done", 32'(mul_stall_EX), 32'd0);
      tick();
   endtask

   initial begin
      logic [31:0] prev;
      int          d0;

      rst_n        = 1'b0;
      mul_start_EX = 1'b0;
      flush_EX     = 1'b0;
      rs1_val_EX   = '0;
      rs2_val_EX   = '0;
      tick();
      tick();
      check("rst_stall", 32'(mul_stall_EX), 32'd0);
      check("rst_busy", 32'(mul_busy_EX), 32'd0);
      check("rst_done", 32'(mul_done_EX), 32'd0);
      check("rst_result", mul_result_EX, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // Directed literal products
      run_mul(32'd7, 32'd6, 32'd42, 0);
      mul_start_EX = 1'b0;
      tick();
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0);
      run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
      mul_start_EX = 1'b0;
      tick();

      // Late forwarding change on rs1 is ignored
      run_mul(32'd123, 32'd1000, 32'd123000, 5);
      mul_start_EX = 1'b0;
      tick();

      // Flush in BUSY cycle 10
      prev = mul_result_EX;
      d0   = n_done;
      mul_start_EX = 1'b1;
      rs1_val_EX   = 32'd9;
      rs2_val_EX   = 32'd9;
      for (int cyc = 2; cyc <= 10; cyc++) tick();
      flush_EX = 1'b1;
      tick();
      flush_EX     = 1'b0;
      mul_start_EX = 1'b0;
      #1;
      check("flush_stall", 32'(mul_stall_EX), 32'd0);
      check("flush_busy", 32'(mul_busy_EX), 32'd0);
      for (int i = 0; i < ITERS + 4; i++) tick();
      check("flush_result", mul_result_EX, prev);
      check("flush_no_done", 32'(n_done - d0), 32'd0);
      run_mul(32'd3, 32'd4, 32'd12, 0);
      mul_start_EX = 1'b0;
      tick();

      // Asynchronous reset in BUSY cycle 20
      mul_start_EX = 1'b1;
      rs1_val_EX   = 32'd11;
      rs2_val_EX   = 32'd13;
      for (int cyc = 2; cyc <= 20; cyc++) tick();
      #2;
      mul_start_EX = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("arst_stall", 32'(mul_stall_EX), 32'd0);
      check("arst_busy", 32'(mul_busy_EX), 32'd0);
      check("arst_done", 32'(mul_done_EX), 32'd0);
      check("arst_result", mul_result_EX, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("idle_after_rst", 32'(mul_busy_EX), 32'd0);

      // Back-to-back with start held through DONE
      d0 = n_done;
      run_mul(32'd2, 32'd3, 32'd6, 0);
      run_mul(32'd5, 32'd5, 32'd25, 0);
      mul_start_EX = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("b2b_done_pulses", 32'(n_done - d0), 32'd2);

      // Randomized traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         mul_start_EX = ($urandom_range(0, 9) != 0);
         flush_EX     = ($urandom_range(0, 59) == 0);
         rs1_val_EX   = $urandom;
         rs2_val_EX   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         tick();
      end
      mul_start_EX = 1'b0;
      flush_EX     = 1'b0;
      for (int i = 0; i < ITERS + 4; i++) tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
